// File: rtl/cordic_angle_sequencer.sv
// cordic_angle_sequencer
//
// Upstream stage of the CORDIC controller. One angle is accepted per
// transaction over a valid/ready handshake and held on z_out for the
// controller. After a one-cycle core_start pulse the sequencer walks ITER
// iteration cycles. In each cycle it records the controller's dir_gt bit
// into out_dir and flags the inconsistent comparator case (lt and gt both
// high). On the last iteration it captures core_result. The transaction
// result is then offered on an output valid/ready handshake.
//
// FSM: IDLE -> LOAD -> RUN -> HOLD -> IDLE.
// out_valid is registered from the HOLD state. As a result, the first HOLD
// cycle only settles the captured data, and out_valid rises one edge after
// HOLD is entered.
//
// Optional feature macro: CORDIC_SEQ_SAT_EN
//   defined   : an out-of-range angle is saturated to ANGLE_MAX and still
//               runs the full LOAD/RUN sequence, with out_err set.
//   undefined : an out-of-range angle skips LOAD/RUN and goes straight to
//               HOLD with out_err=1, out_result=0 and out_dir=0.
//
// Ports
//   CLK          in   1      clock, rising edge
//   RST          in   1      synchronous active-high reset
//   in_valid     in   1      upstream angle valid
//   in_ready     out  1      sequencer can accept an angle (IDLE, not in reset)
//   in_angle     in   WIDTH  angle, sampled on in_valid && in_ready
//   z_out        out  WIDTH  held angle for the controller z input
//   core_start   out  1      one-cycle pulse restarting the controller
//   dir_lt       in   1      controller comparator less-than
//   dir_gt       in   1      controller comparator greater-than
//   core_result  in   WIDTH  controller result, sampled on the last RUN cycle
//   out_valid    out  1      result transaction valid
//   out_ready    in   1      downstream accepts the result
//   out_result   out  WIDTH  captured core_result (0 when skipped on error)
//   out_dir      out  ITER   direction vector, bit i = dir_gt of iteration i
//   out_err      out  1      out-of-range angle or comparator inconsistency
module cordic_angle_sequencer #(
  parameter int WIDTH     = 6,
  parameter int ITER      = 6,
  parameter int ANGLE_MAX = 45
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_angle,
  output logic [WIDTH-1:0] z_out,
  output logic             core_start,
  input  logic             dir_lt,
  input  logic             dir_gt,
  input  logic [WIDTH-1:0] core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [ITER-1:0]  out_dir,
  output logic             out_err
);

  // The counter can reach ITER on the final RUN edge without wrapping.
  localparam int               CNT_W       = $clog2(ITER) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ITER - 1);
  localparam logic [WIDTH-1:0] ANGLE_MAX_V = WIDTH'(ANGLE_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] z_out_q,      z_out_d;
  logic             core_start_q, core_start_d;
  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [ITER-1:0]  out_dir_q,    out_dir_d;
  logic             out_err_q,    out_err_d;

  logic accept;

  function automatic logic angle_illegal(input logic [WIDTH-1:0] a);
    return a > ANGLE_MAX_V;
  endfunction

`ifdef CORDIC_SEQ_SAT_EN
  function automatic logic [WIDTH-1:0] sat_angle(input logic [WIDTH-1:0] a);
    return angle_illegal(a) ? ANGLE_MAX_V : a;
  endfunction
`endif

  assign in_ready = (state_q == S_IDLE) && !RST;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    z_out_d      = z_out_q;
    core_start_d = 1'b0;
    out_valid_d  = 1'b0;
    out_result_d = out_result_q;
    out_dir_d    = out_dir_q;
    out_err_d    = out_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Result fields are cleared at accept so that nothing from the
          // previous transaction leaks into this one.
          out_dir_d    = '0;
          out_result_d = '0;
          out_err_d    = angle_illegal(in_angle);
`ifdef CORDIC_SEQ_SAT_EN
          z_out_d      = sat_angle(in_angle);
          core_start_d = 1'b1;
          state_d      = S_LOAD;
`else
          z_out_d      = in_angle;
          if (angle_illegal(in_angle)) begin
            state_d = S_HOLD;
          end else begin
            core_start_d = 1'b1;
            state_d      = S_LOAD;
          end
`endif
        end
      end

      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        for (int i = 0; i < ITER; i++) begin
          if (cnt_q == CNT_W'(i)) out_dir_d[i] = dir_gt;
        end
        if (dir_lt && dir_gt) out_err_d = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          out_result_d = core_result;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      z_out_q      <= '0;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_dir_q    <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      z_out_q      <= z_out_d;
      core_start_q <= core_start_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_dir_q    <= out_dir_d;
      out_err_q    <= out_err_d;
    end
  end

  assign z_out      = z_out_q;
  assign core_start = core_start_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_dir    = out_dir_q;
  assign out_err    = out_err_q;

endmodule
